// File: rtl/fpu_operand_issue_pkg.sv
// Shared types for the FPU operand issue path: IEEE-754 single words,
// operand classes and the classifier used when an operand set is captured.
package fpu_operand_issue_pkg;

  typedef logic [31:0] real_t;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    SUBNORM = 3'd1,
    NORMAL  = 3'd2,
    INF     = 3'd3,
    QNAN    = 3'd4,
    SNAN    = 3'd5
  } fp_class_t;

  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam int         FP_QBIT    = 22;

  // Sign bit is irrelevant to the class; only exponent and fraction matter.
  function automatic fp_class_t fp_classify(input real_t a);
    logic [7:0]  e;
    logic [22:0] f;
    e = a[30:23];
    f = a[22:0];
    if (e == 8'h00) begin
      fp_classify = (f == 23'd0) ? ZERO : SUBNORM;
    end else if (e != FP_EXP_MAX) begin
      fp_classify = NORMAL;
    end else if (f == 23'd0) begin
      fp_classify = INF;
    end else if (f[FP_QBIT]) begin
      fp_classify = QNAN;
    end else begin
      fp_classify = SNAN;
    end
  endfunction

endpackage

// File: rtl/fpu_operand_issue_arg_fifo.sv
// Generic synchronous FIFO. A push while full is only taken when a pop
// frees the head slot in the same cycle. Storage is not reset.
module fpu_arg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Write the incoming entry into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Advance pointers (natural wrap) and track occupancy separately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      if (do_push && !do_pop)      level_q <= level_q + LVL_ONE;
      else if (do_pop && !do_push) level_q <= level_q - LVL_ONE;
    end
  end

endmodule

// File: rtl/fpu_operand_issue.sv
// Turns the level-sampled operand bus into a counted valid/ready stream:
// every change captures, classifies and sequence-tags the operand set.
module fpu_operand_issue
  import fpu_operand_issue_pkg::*;
#(
  parameter int N_ARG = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  real_t     [N_ARG-1:0]  i_args,
  output logic                   o_valid,
  input  logic                   i_ready,
  output real_t     [N_ARG-1:0]  o_args,
  output fp_class_t [N_ARG-1:0]  o_class,
  output logic [7:0]             o_seq,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);
  typedef struct packed {
    real_t     [N_ARG-1:0] args;
    fp_class_t [N_ARG-1:0] cls;
    logic      [7:0]       seq;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  real_t [N_ARG-1:0] prev_q;
  logic [7:0]        seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic              push_req, push_ok, pop, full, empty;
  entry_t            wr_entry, rd_entry, head;

  // Change detect: an unknown compare result leaves push_req at 0
  always_comb begin
    push_req = 1'b0;
    if (i_args != prev_q) push_req = 1'b1;
  end

  assign pop     = !empty && i_ready;
  assign push_ok = push_req && (!full || pop);

  // Build the entry: operands, per-operand class and the current tag
  always_comb begin
    wr_entry      = '0;
    wr_entry.args = i_args;
    wr_entry.seq  = seq_q;
    for (int i = 0; i < N_ARG; i++) wr_entry.cls[i] = fp_classify(i_args[i]);
  end

  // Tag advances only on accepted pushes; overflow is sticky on a dropped set
  always_comb begin
    seq_d = push_ok ? seq_q + 8'd1 : seq_q;
    ovf_d = ovf_q | (push_req && full && !pop);
  end

  // Operand history, sequence counter and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= i_args;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
    end
  end

  fpu_arg_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (o_level)
  );

  // Head fields read as zero while nothing is queued (including after reset)
  always_comb begin
    head = empty ? '0 : rd_entry;
  end

  assign o_valid    = !empty;
  assign o_args     = head.args;
  assign o_class    = head.cls;
  assign o_seq      = head.seq;
  assign o_overflow = ovf_q;

endmodule

// File: doc/fpu_operand_issue.md
# fpu_operand_issue

Consumes the free-running operand bus from the FPU stimulus generator and converts it into a valid/ready transaction stream for the FPU core. Each time any operand word changes, the block captures the full operand set, classifies every operand per IEEE-754 single precision, tags the set with a sequence number and queues it in a small FIFO. It sits between the generator and the FPU core (or scoreboard), replacing level-sampled operands with discrete, counted operations.

## Interface
- `N_ARG`, default 3: number of operands per operation.
- `DEPTH`, default 4: FIFO depth in entries. Must be a power of two and at least 2.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset. Asynchronous assert, active-low.
- `i_args` input, `real_t [N_ARG-1:0]`: operand bus. Each `real_t` is a 32-bit IEEE-754 single.
- `o_valid` output, 1 bit: head entry is available.
- `i_ready` input, 1 bit: downstream accepts the head entry.
- `o_args` output, `real_t [N_ARG-1:0]`: operands of the head entry.
- `o_class` output, `fp_class_t [N_ARG-1:0]`: per-operand class of the head entry.
- `o_seq` output, 8 bits: sequence tag of the head entry.
- `o_level` output, `$clog2(DEPTH)+1` bits: current FIFO occupancy.
- `o_overflow` output, 1 bit: sticky flag, set when an operand set is dropped.

## Operation
- **Change detection.**
  - `prev_args` registers `i_args` every cycle.
  - A push request occurs when `i_args != prev_args` evaluates to a definite 1.
  - An X/unknown compare result is treated as no change. As a result, the undriven generator bus after reset produces no pushes.
- **Classification.** Performed at push time and stored with the entry:
  - ZERO=0: exp=0, frac=0.
  - SUBNORM=1: exp=0, frac≠0.
  - NORMAL=2: exp in 1..254.
  - INF=3: exp=255, frac=0.
  - QNAN=4: exp=255, frac[22]=1.
  - SNAN=5: exp=255, frac[22]=0, frac≠0.
  - Classification ignores the sign bit.
- **Entry contents.** `{args, class, seq}`.
  - `seq` comes from an 8-bit counter that increments on every accepted push and wraps 255→0.
- **Pop.** Occurs on `o_valid && i_ready`.
- **Full FIFO.**
  - Push while full with no simultaneous pop: the entry is dropped, `seq` is not incremented, and `o_overflow` is set. `o_overflow` clears only on reset.
  - Push while full with a simultaneous pop: the push is accepted and the level is unchanged.
- **Empty FIFO.** Push while empty: the entry becomes the head on the next cycle. There is no same-cycle bypass.
- **Downstream protocol.**
  - `o_args`, `o_class` and `o_seq` are stable while `o_valid && !i_ready`.
  - `o_valid` does not drop until the entry is popped.
- **Pointer arithmetic.** Read/write pointers are `$clog2(DEPTH)` bits and wrap naturally. The level is tracked as a separate counter.

## Timing
- **Latency.** An `i_args` change at the edge k output is detected at edge k+1. `o_valid` is high from edge k+1 (head visible in cycle k+1). Change-to-valid latency is one cycle.
- **Throughput.** One push and one pop per cycle.
- **Reset values (asynchronous on `rst_n`=0):**
  - `o_valid`=0, `o_level`=0, `o_overflow`=0, `o_seq`=0.
  - `o_args`=0, `o_class`=ZERO.
  - `prev_args`=0, `seq` counter=0, pointers=0.
- **Reset mid-operation.** All queued entries are discarded. The first change after release is tagged `seq`=0.
- **Back-to-back changes.** Changes on consecutive cycles each produce a push, one per cycle.

## Structure
- **`fpu_pack` additions:**
  - `fp_class_t`: 3-bit enum with the values above.
  - `fp_classify(real_t)` function.
  - Constants `FP_EXP_MAX=8'hFF` and `FP_QBIT=22`.
- **Sub-module.** `fpu_arg_fifo`, a generic DEPTH × width synchronous FIFO with push/pop/full/empty/level.
- **Top level.** Contains change detection, classification, the seq counter, and the overflow flag.

## Test plan
- **Single change.** Drive `{8.12, -1.14, 2.41}` = `{0x4101EB85, 0xBF91EB85, 0x401A3D71}` with `i_ready`=1.
  - Expect one transaction one cycle later: those words, classes `{NORMAL, NORMAL, NORMAL}`, `o_seq`=0.
- **Classification sweep.** Drive operands 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000, 0x7F800001.
  - Expect ZERO, SUBNORM, INF, QNAN, SNAN respectively.
- **Overflow.** With `i_ready`=0, drive 6 distinct sets on consecutive cycles.
  - Expect `o_level`=4, `o_overflow`=1, and seqs 0..3 retained.
  - Raising `i_ready` drains exactly 4 entries in order.
- **Full + simultaneous.** With the FIFO full, pulse `i_ready`=1 in the same cycle as a new change.
  - Expect the push accepted (seq 4), level stays 4, and `o_overflow` unchanged.
- **Reset mid-stream.** With 3 entries queued, assert `rst_n`=0 between edges.
  - Expect `o_valid`=0 immediately.
  - After release, the next change yields `o_seq`=0.
- **Stall stability.** Hold `i_ready`=0 for 10 cycles while `i_args` is unchanged.
  - Expect `o_args`/`o_class`/`o_seq` constant and `o_level`=1.
